// File: rtl/softreg_param_bank_if.sv
// ============================================================================
// Module      : softreg_param_bank_if
// Description : SoftReg host request/response bundle (host = master).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface softreg_param_bank_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              softreg_req_valid;
  logic              softreg_req_isWrite;
  logic [ADDR_W-1:0] softreg_req_addr;
  logic [DATA_W-1:0] softreg_req_data;
  logic              softreg_resp_valid;
  logic [DATA_W-1:0] softreg_resp_data;

  modport master (
    output softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
    input  softreg_resp_valid, softreg_resp_data
  );

  modport slave (
    input  softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
    output softreg_resp_valid, softreg_resp_data
  );
endinterface

`default_nettype wire

// File: rtl/softreg_param_bank.sv
// ============================================================================
// Module      : softreg_param_bank
// Description : SoftReg decoder for PageRank run parameters, start/done
//               sequencing and a deferred DONE_ALL read response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module softreg_param_bank #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  softreg_param_bank_if.slave softreg,
  output logic [DATA_W-1:0] n_vert,
  output logic [DATA_W-1:0] n_inedges,
  output logic [DATA_W-1:0] vaddr,
  output logic [DATA_W-1:0] ieaddr,
  output logic [DATA_W-1:0] write_addr0,
  output logic [DATA_W-1:0] write_addr1,
  output logic [DATA_W-1:0] n_rounds,
  output logic              start,
  output logic              busy,
  output logic              cfg_err,
  input  logic              engine_done,
  input  logic [DATA_W-1:0] engine_result
);

  localparam logic [ADDR_W-1:0] c_N_VERT           = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_N_INEDGES        = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_VADDR            = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_IEADDR           = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] c_WRITE_ADDR0      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_WRITE_ADDR1      = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] c_N_ROUNDS         = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] c_DONE_READ_PARAMS = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] c_DONE_ALL         = ADDR_W'(8);

  typedef enum logic [1:0] {
    S_CONFIG = 2'd0,
    S_RUN    = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_n_vert, r_n_inedges, r_vaddr, r_ieaddr;
  logic [DATA_W-1:0] r_write_addr0, r_write_addr1, r_n_rounds;
  logic [DATA_W-1:0] r_result;
  logic              r_start, r_cfg_err, r_pending, r_defer;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;

  logic              w_wr, w_rd, w_params_ok, w_done_evt, w_outstanding;
  logic              w_start_nxt, w_err_set;
  logic              w_new_resp, w_set_pending, w_pend_due;
  logic [DATA_W-1:0] w_new_data, w_pend_data;

  assign w_wr          = softreg.softreg_req_valid &  softreg.softreg_req_isWrite;
  assign w_rd          = softreg.softreg_req_valid & ~softreg.softreg_req_isWrite;
  assign w_params_ok   = (r_n_vert != '0) && (r_n_rounds != '0);
  assign w_done_evt    = (r_state == S_RUN) && engine_done;
  assign w_outstanding = r_pending | r_defer;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_CONFIG;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_CONFIG: begin
        if (w_wr && softreg.softreg_req_addr == c_DONE_READ_PARAMS) begin
          if (w_params_ok) begin
            w_state_nxt = S_RUN;
            w_start_nxt = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (engine_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_wr && softreg.softreg_req_addr == c_DONE_ALL) w_state_nxt = S_CONFIG;
      end
      default: w_state_nxt = S_CONFIG;
    endcase
  end

  // ---------------- read decode ----------------
  always_comb begin
    w_new_resp    = 1'b0;
    w_new_data    = '0;
    w_set_pending = 1'b0;
    if (w_rd) begin
      w_new_resp = 1'b1;
      case (softreg.softreg_req_addr)
        c_N_VERT:           w_new_data = r_n_vert;
        c_N_INEDGES:        w_new_data = r_n_inedges;
        c_VADDR:            w_new_data = r_vaddr;
        c_IEADDR:           w_new_data = r_ieaddr;
        c_WRITE_ADDR0:      w_new_data = r_write_addr0;
        c_WRITE_ADDR1:      w_new_data = r_write_addr1;
        c_N_ROUNDS:         w_new_data = r_n_rounds;
        c_DONE_READ_PARAMS: w_new_data = DATA_W'(r_state);
        c_DONE_ALL: begin
          // A DONE_ALL read with a response already owed merges into it.
          if (w_outstanding) begin
            w_new_resp = 1'b0;
          end else if (r_state == S_DONE) begin
            w_new_data = r_result;
          end else if (w_done_evt) begin
            w_new_data = engine_result;
          end else begin
            w_new_resp    = 1'b0;
            w_set_pending = 1'b1;
          end
        end
        default:            w_new_data = '0;
      endcase
    end
  end

  assign w_pend_due  = (r_pending & w_done_evt) | r_defer;
  assign w_pend_data = r_defer ? r_result : engine_result;

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_vert      <= '0;
      r_n_inedges   <= '0;
      r_vaddr       <= '0;
      r_ieaddr      <= '0;
      r_write_addr0 <= '0;
      r_write_addr1 <= '0;
      r_n_rounds    <= '0;
    end else if (w_wr && r_state == S_CONFIG) begin
      case (softreg.softreg_req_addr)
        c_N_VERT:      r_n_vert      <= softreg.softreg_req_data;
        c_N_INEDGES:   r_n_inedges   <= softreg.softreg_req_data;
        c_VADDR:       r_vaddr       <= softreg.softreg_req_data;
        c_IEADDR:      r_ieaddr      <= softreg.softreg_req_data;
        c_WRITE_ADDR0: r_write_addr0 <= softreg.softreg_req_data;
        c_WRITE_ADDR1: r_write_addr1 <= softreg.softreg_req_data;
        c_N_ROUNDS:    r_n_rounds    <= softreg.softreg_req_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start      <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_result     <= '0;
      r_pending    <= 1'b0;
      r_defer      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_start <= w_start_nxt;
      if (w_err_set)        r_cfg_err <= 1'b1;
      else if (w_start_nxt) r_cfg_err <= 1'b0;
      if (w_done_evt) r_result <= engine_result;

      if (w_set_pending)
        r_pending <= 1'b1;
      else if (w_done_evt || (r_state == S_DONE && w_state_nxt == S_CONFIG))
        r_pending <= 1'b0;

      // A fresh read takes the response slot; an owed DONE_ALL waits one more.
      r_defer      <= w_pend_due & w_new_resp;
      r_resp_valid <= w_new_resp | w_pend_due;
      if (w_new_resp)      r_resp_data <= w_new_data;
      else if (w_pend_due) r_resp_data <= w_pend_data;
      else                 r_resp_data <= '0;
    end
  end

  assign n_vert      = r_n_vert;
  assign n_inedges   = r_n_inedges;
  assign vaddr       = r_vaddr;
  assign ieaddr      = r_ieaddr;
  assign write_addr0 = r_write_addr0;
  assign write_addr1 = r_write_addr1;
  assign n_rounds    = r_n_rounds;
  assign start       = r_start;
  assign busy        = (r_state == S_RUN);
  assign cfg_err     = r_cfg_err;

  assign softreg.softreg_resp_valid = r_resp_valid;
  assign softreg.softreg_resp_data  = r_resp_data;

endmodule

`default_nettype wire

// File: tb/tb_softreg_param_bank.sv
// ============================================================================
// Module      : tb_softreg_param_bank
// Description : Directed vector-table bench for softreg_param_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_softreg_param_bank;

  localparam logic [31:0] A_N_VERT      = 32'd0;
  localparam logic [31:0] A_N_INEDGES   = 32'd1;
  localparam logic [31:0] A_VADDR       = 32'd2;
  localparam logic [31:0] A_IEADDR      = 32'd3;
  localparam logic [31:0] A_WA0         = 32'd4;
  localparam logic [31:0] A_WA1         = 32'd5;
  localparam logic [31:0] A_N_ROUNDS    = 32'd6;
  localparam logic [31:0] A_DRP         = 32'd7;
  localparam logic [31:0] A_DONE_ALL    = 32'd8;
  localparam logic [31:0] A_UNKNOWN     = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] n_vert, n_inedges, vaddr, ieaddr, write_addr0, write_addr1, n_rounds;
  logic        start, busy, cfg_err;
  logic        engine_done;
  logic [63:0] engine_result;

  always #5 clk = ~clk;

  softreg_param_bank_if #(.DATA_W(64), .ADDR_W(32)) sr ();

  softreg_param_bank #(.DATA_W(64), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .softreg       (sr),
    .n_vert        (n_vert),
    .n_inedges     (n_inedges),
    .vaddr         (vaddr),
    .ieaddr        (ieaddr),
    .write_addr0   (write_addr0),
    .write_addr1   (write_addr1),
    .n_rounds      (n_rounds),
    .start         (start),
    .busy          (busy),
    .cfg_err       (cfg_err),
    .engine_done   (engine_done),
    .engine_result (engine_result)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic        exp_v;
    logic [63:0] exp_d;
  } vec_t;

  vec_t vecs [16];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] a, input logic [63:0] d);
    sr.softreg_req_valid   = 1'b1;
    sr.softreg_req_isWrite = wr;
    sr.softreg_req_addr    = a;
    sr.softreg_req_data    = d;
    tick();
    sr.softreg_req_valid   = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic v, input logic [63:0] d);
    check({name, ".valid"}, {63'd0, sr.softreg_resp_valid}, {63'd0, v});
    if (v) check({name, ".data"}, sr.softreg_resp_data, d);
  endtask

  initial begin
    vecs[0]  = '{1'b1, A_N_VERT,    64'd100,   1'b0, 64'd0};
    vecs[1]  = '{1'b1, A_N_INEDGES, 64'd511,   1'b0, 64'd0};
    vecs[2]  = '{1'b1, A_VADDR,     64'd0,     1'b0, 64'd0};
    vecs[3]  = '{1'b1, A_IEADDR,    64'd1600,  1'b0, 64'd0};
    vecs[4]  = '{1'b1, A_WA0,       64'd5688,  1'b0, 64'd0};
    vecs[5]  = '{1'b1, A_WA1,       64'd6488,  1'b0, 64'd0};
    vecs[6]  = '{1'b1, A_N_ROUNDS,  64'd4,     1'b0, 64'd0};
    vecs[7]  = '{1'b0, A_IEADDR,    64'd0,     1'b1, 64'd1600};
    vecs[8]  = '{1'b0, A_UNKNOWN,   64'd0,     1'b1, 64'd0};
    vecs[9]  = '{1'b0, A_N_VERT,    64'd0,     1'b1, 64'd100};
    vecs[10] = '{1'b0, A_DRP,       64'd0,     1'b1, 64'd0};
    vecs[11] = '{1'b1, A_UNKNOWN,   64'hDEAD,  1'b0, 64'd0};
    vecs[12] = '{1'b0, A_WA1,       64'd0,     1'b1, 64'd6488};
    vecs[13] = '{1'b0, A_N_ROUNDS,  64'd0,     1'b1, 64'd4};
    vecs[14] = '{1'b0, A_N_INEDGES, 64'd0,     1'b1, 64'd511};
    vecs[15] = '{1'b0, A_VADDR,     64'd0,     1'b1, 64'd0};

    rst                    = 1'b1;
    engine_done            = 1'b0;
    engine_result          = 64'd0;
    sr.softreg_req_valid   = 1'b0;
    sr.softreg_req_isWrite = 1'b0;
    sr.softreg_req_addr    = 32'd0;
    sr.softreg_req_data    = 64'd0;
    tick();
    tick();
    check("rst.n_vert",   n_vert,   64'd0);
    check("rst.n_rounds", n_rounds, 64'd0);
    check("rst.start",    {63'd0, start},   64'd0);
    check("rst.busy",     {63'd0, busy},    64'd0);
    check("rst.cfg_err",  {63'd0, cfg_err}, 64'd0);
    check("rst.resp",     {63'd0, sr.softreg_resp_valid}, 64'd0);
    rst = 1'b0;
    tick();

    // Configuration and readback table
    for (int i = 0; i < 16; i++) begin
      req(vecs[i].wr, vecs[i].addr, vecs[i].data);
      expect_resp($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_d);
    end
    check("cfg.n_vert", n_vert, 64'd100);
    check("cfg.ieaddr", ieaddr, 64'd1600);
    check("cfg.wa1",    write_addr1, 64'd6488);
    check("cfg.start",  {63'd0, start}, 64'd0);

    // Invalid start then valid start
    req(1'b1, A_N_ROUNDS, 64'd0);
    req(1'b1, A_DRP, 64'd0);
    check("inv.start",   {63'd0, start},   64'd0);
    check("inv.cfg_err", {63'd0, cfg_err}, 64'd1);
    check("inv.busy",    {63'd0, busy},    64'd0);
    req(1'b0, A_DRP, 64'd0);
    expect_resp("inv.state", 1'b1, 64'd0);
    req(1'b1, A_N_ROUNDS, 64'd4);
    req(1'b1, A_DRP, 64'd0);
    check("go.start",   {63'd0, start},   64'd1);
    check("go.busy",    {63'd0, busy},    64'd1);
    check("go.cfg_err", {63'd0, cfg_err}, 64'd0);
    tick();
    check("go.start_1cyc", {63'd0, start}, 64'd0);
    check("go.busy2",      {63'd0, busy},  64'd1);
    check("go.n_inedges",  n_inedges,   64'd511);
    check("go.vaddr",      vaddr,       64'd0);
    check("go.wa0",        write_addr0, 64'd5688);
    check("go.n_rounds",   n_rounds,    64'd4);

    // RUN: state read, ignored writes, deferred DONE_ALL
    req(1'b0, A_DRP, 64'd0);
    expect_resp("run.state", 1'b1, 64'd1);
    req(1'b1, A_N_VERT, 64'd7);
    req(1'b0, A_N_VERT, 64'd0);
    expect_resp("run.nvert_rd", 1'b1, 64'd100);
    check("run.nvert_out", n_vert, 64'd100);
    req(1'b1, A_DRP, 64'd0);
    check("run.restart", {63'd0, start}, 64'd0);
    req(1'b0, A_DONE_ALL, 64'd0);
    expect_resp("defer.none", 1'b0, 64'd0);
    for (int i = 0; i < 19; i++) begin
      tick();
      expect_resp($sformatf("defer.wait%0d", i), 1'b0, 64'd0);
    end
    engine_result = 64'h1234;
    engine_done   = 1'b1;
    tick();
    engine_done   = 1'b0;
    expect_resp("defer.resp", 1'b1, 64'h1234);
    check("defer.busy", {63'd0, busy}, 64'd0);
    tick();
    expect_resp("defer.single", 1'b0, 64'd0);
    req(1'b0, A_DRP, 64'd0);
    expect_resp("done.state", 1'b1, 64'd2);
    req(1'b0, A_DONE_ALL, 64'd0);
    expect_resp("done.read", 1'b1, 64'h1234);
    req(1'b1, A_DONE_ALL, 64'd0);
    expect_resp("done.wr_noresp", 1'b0, 64'd0);
    req(1'b0, A_DRP, 64'd0);
    expect_resp("back.state", 1'b1, 64'd0);

    // Collision: pending DONE_ALL and N_VERT read in the engine_done cycle
    req(1'b1, A_DRP, 64'd0);
    check("col.start", {63'd0, start}, 64'd1);
    req(1'b0, A_DONE_ALL, 64'd0);
    expect_resp("col.pend", 1'b0, 64'd0);
    engine_result = 64'hABCD;
    engine_done   = 1'b1;
    req(1'b0, A_N_VERT, 64'd0);
    engine_done   = 1'b0;
    expect_resp("col.first", 1'b1, 64'd100);
    tick();
    expect_resp("col.second", 1'b1, 64'hABCD);
    tick();
    expect_resp("col.after", 1'b0, 64'd0);
    req(1'b1, A_DONE_ALL, 64'd0);

    // Merged DONE_ALL reads
    req(1'b1, A_DRP, 64'd0);
    req(1'b0, A_DONE_ALL, 64'd0);
    req(1'b0, A_DONE_ALL, 64'd0);
    expect_resp("merge.none", 1'b0, 64'd0);
    engine_result = 64'h77;
    engine_done   = 1'b1;
    tick();
    engine_done   = 1'b0;
    expect_resp("merge.resp", 1'b1, 64'h77);
    tick();
    expect_resp("merge.single", 1'b0, 64'd0);
    req(1'b1, A_DONE_ALL, 64'd0);

    // Same-cycle engine_done and DONE_ALL read
    req(1'b1, A_DRP, 64'd0);
    engine_result = 64'h55;
    engine_done   = 1'b1;
    req(1'b0, A_DONE_ALL, 64'd0);
    engine_done   = 1'b0;
    expect_resp("same.resp", 1'b1, 64'h55);
    tick();
    expect_resp("same.single", 1'b0, 64'd0);
    req(1'b1, A_DONE_ALL, 64'd0);

    // Reset mid-RUN with a pending read
    req(1'b1, A_DRP, 64'd0);
    req(1'b0, A_DONE_ALL, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mrst.n_vert",   n_vert,   64'd0);
    check("mrst.ieaddr",   ieaddr,   64'd0);
    check("mrst.n_rounds", n_rounds, 64'd0);
    check("mrst.busy",     {63'd0, busy},  64'd0);
    check("mrst.start",    {63'd0, start}, 64'd0);
    check("mrst.resp",     {63'd0, sr.softreg_resp_valid}, 64'd0);
    tick();
    rst = 1'b0;
    engine_result = 64'h99;
    engine_done   = 1'b1;
    tick();
    engine_done   = 1'b0;
    expect_resp("mrst.nores0", 1'b0, 64'd0);
    tick();
    expect_resp("mrst.nores1", 1'b0, 64'd0);
    req(1'b0, A_DRP, 64'd0);
    expect_resp("mrst.state", 1'b1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
